alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter N, default 8, giving the datapath width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, begin operation; sampled on rising clk.
REQ-005 SHALL have port op, input, 3, operation select; sampled with start.
REQ-006 SHALL have ports data_in_a and data_in_b, input, N each, operands; sampled with start.
REQ-007 SHALL have port flags_load_enable, input, 1, update the flag register on completion of this operation; sampled with start.
REQ-008 SHALL have port output_alu, input, 1, drive the result register onto data_out.
REQ-009 SHALL have port data_out, output, N, result register when output_alu=1, else all zeros (combinational gate).
REQ-010 SHALL have port flags_out, output, 4, registered {C,Z,N,V} with C at bit 3.
REQ-011 SHALL have port busy, output, 1, high while a multi-cycle operation runs.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the result register is updated.

Function
REQ-013 SHALL decode op as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL a by 1, 110 SHR a by 1 (logical), 111 MUL (low N bits of a*b, unsigned).
REQ-014 SHALL, for ops 000-110, load the result register on the edge that samples start=1 with busy=0, and assert done for the following cycle.
REQ-015 SHALL compute SUB as a + ~b + 1 over N+1 bits.
REQ-016 SHALL implement MUL as an iterative shift-add using FSM states IDLE and MUL_RUN: start edge -> MUL_RUN, busy=1, counter=0; N iteration edges; on the Nth edge load the result, return to IDLE, busy=0, and done=1 for the next cycle.
REQ-017 SHALL ignore start while busy=1, leaving operands, op and flags_load_enable latched at the original start.
REQ-018 SHALL set flag C to the carry out for ADD/SUB (SUB: C=1 means no borrow), to the shifted-out bit for SHL/SHR, to 1 if the upper N product bits are nonzero for MUL, and to 0 for logic ops.
REQ-019 SHALL set flag Z = (result == 0) and flag N = result[N-1] for every op.
REQ-020 SHALL set flag V to two's-complement overflow for ADD/SUB and to 0 for all other ops.
REQ-021 SHALL write the flags only at the result-load edge, and only if the latched flags_load_enable=1; otherwise flags_out holds its value.
REQ-022 SHALL allow a new start in the cycle done is high; that start is accepted normally.
REQ-023 SHALL make output_alu affect only data_out and never the internal state.

Reset
REQ-024 SHALL, while rst=1 and irrespective of clk, force: state IDLE, counter 0, result register 0, flags 0, busy 0, done 0; data_out is therefore 0.
REQ-025 SHALL have rst during MUL_RUN abort the operation with no done pulse and no change to the result or flags after release.
REQ-026 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the op encodings, flag bit indices and FSM state encoding in shared package alu_mc_pkg.
REQ-028 SHALL implement the iterative multiplier datapath (accumulator, shifted multiplicand, counter) as sub-module shift_add_mul, parameterised by N.

Verification (N=8)
REQ-029 SHALL test: ADD 0x0F+0xF0, load=1 -> 0xFF, flags C0 Z0 N1 V0, done 1 cycle after the start edge; SUB 0xFF-0x8F -> 0x70, C1 Z0 N0 V0.
REQ-030 SHALL test: ADD 0x7F+0x01 -> 0x80 with V1 N1; ADD 0xFF+0x01 -> 0x00 with C1 Z1; SUB 0x05-0x05 -> 0x00 with Z1 C1.
REQ-031 SHALL test: MUL 0x0F*0x11 -> 0xFF, C0, busy high 8 cycles; a start asserted mid-run is ignored; MUL 0x10*0x10 -> 0x00 with C1 Z1.
REQ-032 SHALL test: AND 0xF0,0x3C with load=0 -> result 0x30 and flags unchanged; with output_alu=0, data_out=0x00.
REQ-033 SHALL test: SHL 0x81 -> 0x02 with C1; SHR 0x01 -> 0x00 with C1 Z1.
REQ-034 SHALL test: rst asserted asynchronously on MUL cycle 4 -> all outputs 0 immediately with no done; after release, ADD 0x01+0x01 -> 0x02.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op encodings, flag bit
// positions, FSM state encoding and a flag-packing helper.
package alu_mc_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 4;

    // Flag bit positions inside flags_out ({C,Z,N,V})
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_e;

    // Assemble a flag word from individual bits
    function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic z,
                                                      input logic n, input logic v);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier datapath: one partial product per step.
// Ports:
//   clk, rst      clock, async active-high reset
//   load_i        capture operands, clear accumulator and counter
//   step_i        perform one shift-add iteration
//   a_i, b_i      multiplicand / multiplier (N bits)
//   prod_c_o      accumulator value after the current step (2N bits, comb)
//   last_c_o      current step is the final (Nth) iteration (comb)
module shift_add_mul
    import alu_mc_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] prod_c_o,
    output logic           last_c_o
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] mcand_q;
    logic [N-1:0]  mplier_q;
    logic [CW-1:0] cnt_q;

    // Add the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_c_o = acc_d;
        last_c_o = step_i && (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= PW'(a_i);
            mplier_q <= b_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift ops and an N-cycle
// iterative multiply, with a registered result and {C,Z,N,V} flag register.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               begin an operation (ignored while busy)
//   op                  operation select (see alu_mc_pkg::op_e)
//   data_in_a/b         operands, sampled with start
//   flags_load_enable   update flags when this operation completes
//   output_alu          gate the result register onto data_out
//   data_out            result register or zero (combinational gate)
//   flags_out           flag register {C,Z,N,V}
//   busy                multiply in progress
//   done                one-cycle pulse after the result register loads
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [N-1:0]      data_in_a,
    input  logic [N-1:0]      data_in_b,
    input  logic              flags_load_enable,
    input  logic              output_alu,
    output logic [N-1:0]      data_out,
    output logic [FLAG_W-1:0] flags_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SW = N + 1;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [N-1:0]      result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              load_en_q, load_en_d;

    op_e               op_sel;
    logic [N-1:0]      b_eff;
    logic [SW-1:0]     sum;
    logic [N-1:0]      alu_res;
    logic              alu_c, alu_v;
    logic [FLAG_W-1:0] alu_flags;

    logic              mul_load, mul_step, mul_last;
    logic [2*N-1:0]    mul_prod;
    logic [N-1:0]      mul_res;
    logic [FLAG_W-1:0] mul_flags;

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1
    always_comb begin
        op_sel  = op_e'(op);
        b_eff   = (op_sel == OP_SUB) ? ~data_in_b : data_in_b;
        sum     = {1'b0, data_in_a} + {1'b0, b_eff} + SW'(op_sel == OP_SUB);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_sel)
            OP_ADD, OP_SUB: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (data_in_a[N-1] == b_eff[N-1]) && (alu_res[N-1] != data_in_a[N-1]);
            end
            OP_AND: alu_res = data_in_a & data_in_b;
            OP_OR:  alu_res = data_in_a | data_in_b;
            OP_XOR: alu_res = data_in_a ^ data_in_b;
            OP_SHL: begin
                alu_res = {data_in_a[N-2:0], 1'b0};
                alu_c   = data_in_a[N-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, data_in_a[N-1:1]};
                alu_c   = data_in_a[0];
            end
            default: ;
        endcase
        alu_flags = pack_flags(alu_c, alu_res == '0, alu_res[N-1], alu_v);
    end

    // Carry for MUL reports that the product did not fit in N bits
    always_comb begin
        mul_res   = mul_prod[N-1:0];
        mul_flags = pack_flags(|mul_prod[2*N-1:N], mul_res == '0, mul_res[N-1], 1'b0);
    end

    assign mul_step = (state_q == MUL_RUN);

    shift_add_mul #(.N(N)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .load_i   (mul_load),
        .step_i   (mul_step),
        .a_i      (data_in_a),
        .b_i      (data_in_b),
        .prod_c_o (mul_prod),
        .last_c_o (mul_last)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        result_d  = result_q;
        flags_d   = flags_q;
        load_en_d = load_en_q;
        mul_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_sel == OP_MUL) begin
                        state_d   = MUL_RUN;
                        busy_d    = 1'b1;
                        mul_load  = 1'b1;
                        load_en_d = flags_load_enable;
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                        if (flags_load_enable) flags_d = alu_flags;
                    end
                end
            end
            MUL_RUN: begin
                busy_d = 1'b1;
                if (mul_last) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = mul_res;
                    if (load_en_q) flags_d = mul_flags;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            load_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            load_en_q <= load_en_d;
        end
    end

    assign data_out  = output_alu ? result_q : '0;
    assign flags_out = flags_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (N=8): the driver pushes hand-computed
// results, the monitor pops and compares on every done pulse.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       flags_load_enable = 1'b0;
    logic       output_alu = 1'b1;
    logic [7:0] data_out;
    logic [3:0] flags_out;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] d;
        logic [3:0] f;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    alu_mc #(.N(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .op                (op),
        .data_in_a         (a),
        .data_in_b         (b),
        .flags_load_enable (flags_load_enable),
        .output_alu        (output_alu),
        .data_out          (data_out),
        .flags_out         (flags_out),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [3:0] f, input string name);
        exp_t t;
        t.d    = d;
        t.f    = f;
        t.name = name;
        sb.push_back(t);
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                e = sb.pop_front();
                check({e.name, " data"}, 32'(data_out), 32'(e.d));
                check({e.name, " flags"}, 32'(flags_out), 32'(e.f));
            end
        end
    end

    // Single-cycle op: done must be visible one cycle after the start edge
    task automatic run_alu(input op_e o, input logic [7:0] ia, input logic [7:0] ib,
                           input logic ld, input logic [7:0] ed, input logic [3:0] ef,
                           input string name);
        @(negedge clk);
        op = o; a = ia; b = ib; flags_load_enable = ld; start = 1'b1;
        push_exp(ed, ef, name);
        @(negedge clk);
        start = 1'b0;
        check({name, " done"}, 32'(done), 32'd1);
    endtask

    // Multiply: count busy cycles; optionally fire a stray start mid-run
    task automatic run_mul(input logic [7:0] ia, input logic [7:0] ib, input logic ld,
                           input logic [7:0] ed, input logic [3:0] ef,
                           input logic inject, input string name);
        int  busy_cycles;
        bit  seen;
        busy_cycles = 0;
        seen        = 1'b0;
        @(negedge clk);
        op = OP_MUL; a = ia; b = ib; flags_load_enable = ld; start = 1'b1;
        push_exp(ed, ef, name);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (inject && busy_cycles == 3) begin
                    start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01; flags_load_enable = 1'b0;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " busy_cycles"}, 32'(busy_cycles), 32'd8);
    endtask

    initial begin
        // Asynchronous reset: outputs clear before any clock edge
        #1 rst = 1'b1;
        #2;
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset flags", 32'(flags_out), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_alu(OP_ADD, 8'h0F, 8'hF0, 1'b1, 8'hFF, 4'b0010, "add_0f_f0");
        run_alu(OP_SUB, 8'hFF, 8'h8F, 1'b1, 8'h70, 4'b1000, "sub_ff_8f");
        run_alu(OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011, "add_ovf");
        run_alu(OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b1100, "add_carry");
        run_alu(OP_SUB, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1100, "sub_zero");

        run_mul(8'h0F, 8'h11, 1'b1, 8'hFF, 4'b0010, 1'b1, "mul_0f_11");
        run_mul(8'h10, 8'h10, 1'b1, 8'h00, 4'b1100, 1'b0, "mul_10_10");

        // Flags held from the previous MUL; data_out gated off
        output_alu = 1'b0;
        run_alu(OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h00, 4'b1100, "and_noload");
        @(negedge clk);
        output_alu = 1'b1;
        #1 check("and result_reg", 32'(data_out), 32'h30);

        run_alu(OP_SHL, 8'h81, 8'h00, 1'b1, 8'h02, 4'b1000, "shl_81");
        run_alu(OP_SHR, 8'h01, 8'h00, 1'b1, 8'h00, 4'b1100, "shr_01");

        // Abort a multiply on its 4th busy cycle with a mid-cycle reset
        @(negedge clk);
        op = OP_MUL; a = 8'h0F; b = 8'h11; flags_load_enable = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort data_out", 32'(data_out), 32'h00);
        check("abort flags", 32'(flags_out), 32'h0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);

        // Start on the first edge after release
        rst = 1'b0;
        op = OP_ADD; a = 8'h01; b = 8'h01; flags_load_enable = 1'b1; start = 1'b1;
        push_exp(8'h02, 4'b0000, "add_after_rst");
        @(negedge clk);
        start = 1'b0;
        check("add_after_rst done", 32'(done), 32'd1);

        repeat (4) @(negedge clk);
        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
